regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Next-generation register file for the NPC core.
- Provides N combinational read ports, M prioritised write ports, an optional write-to-read bypass, and a per-register busy scoreboard.
- Issue logic uses the scoreboard for RAW/WAW hazard detection on multi-cycle units.
- Sits between decode/issue (reads, reservations) and writeback (writes). The PC+4 link-value select is removed from this block and now lives in writeback.

Parameters:
- ADDR_WIDTH, 5: register index width.
- ADDR_COUNT, 32: number of architectural registers. Must be ≤ 2**ADDR_WIDTH and > 10.
- DATA_WIDTH, 32: register width.
- NR_RD, 2: number of read ports.
- NR_WR, 2: number of write ports. Higher index has higher priority.
- BYPASS, 1: 1 = same-cycle write data is forwarded to reads; 0 = reads see stored state only.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero and never becomes busy.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- rd_addr  in  NR_RD*ADDR_WIDTH  read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NR_RD*DATA_WIDTH  read data, combinational
- rd_busy  out  NR_RD  scoreboard status of each read address
- wr_en  in  NR_WR  write enables
- wr_addr  in  NR_WR*ADDR_WIDTH  write addresses
- wr_data  in  NR_WR*DATA_WIDTH  write data
- rsv_en  in  1  request to reserve a destination register (instruction issue)
- rsv_addr  in  ADDR_WIDTH  destination being reserved
- rsv_ok  out  1  reservation accepted this cycle
- a0  out  DATA_WIDTH  stored value of register 10 (ebreak/trap exit code); never bypassed

Behaviour:
- Reset: synchronous and active-low. On any rising edge with rst_n=0:
  - all registers clear to 0 and all busy bits clear to 0;
  - writes and reservations presented that cycle are discarded;
  - reset asserted mid-operation abandons all outstanding reservations.
- Outputs after reset: rd_data = 0 and rd_busy = 0 for every port, a0 = 0, rsv_ok = 1 when rsv_en is high.
- Write: on posedge, for each i with wr_en[i]=1 and a valid address, rf[wr_addr[i]] <= wr_data[i] and busy[wr_addr[i]] <= 0.
  - Valid address: wr_addr < ADDR_COUNT, and wr_addr != 0 when ZERO_REG=1.
- Same-address multi-write: the highest-index port wins. Lower-index ports to that address are dropped.
- Read: zero-latency combinational.
  - rd_data[i] = 0 if the address is ≥ ADDR_COUNT, or if the address is 0 and ZERO_REG=1.
  - Else, when BYPASS=1 and any enabled write port targets the same address, rd_data[i] = data from the highest-index such port.
  - Else rd_data[i] = rf[addr].
- rd_busy[i] = busy[addr], except it is forced to 0 when BYPASS=1 and an enabled write to that address occurs this cycle. Always 0 for addr 0 when ZERO_REG=1, and for out-of-range addresses.
- Reservation:
  - rsv_ok = rsv_en & (~busy[rsv_addr] | same-cycle write to rsv_addr).
  - rsv_ok = rsv_en for addr 0 when ZERO_REG=1; such a reservation has no effect.
  - On posedge with rsv_ok=1 and a valid address, busy[rsv_addr] <= 1.
- Same-cycle reserve and write to the same address: set wins, so busy = 1 next cycle (release followed by a new reservation); the write data is still stored.
- Out-of-range rsv_addr: rsv_ok = 0 and no effect.
- Busy bits are cleared only by a write or by reset; there is no flush port in this generation.
- a0 = rf[10] (stored value).

Decomposition:
- Package rf_pkg holds:
  - constants RF_ADDR_W=5, RF_COUNT=32, RF_DATA_W=32, REG_ZERO=0, REG_A0=10;
  - typedefs rf_addr_t and rf_data_t.
- Sub-module rf_scoreboard: busy vector, reserve/release logic, rsv_ok and rd_busy generation. It takes the write-port addresses and enables as release inputs.
- Storage array, write-priority resolution and the bypass mux stay in regfile_sb.

Test Plan:
- Reset state: hold rst_n=0 for 2 cycles, then release → every read returns 0, rd_busy=0, a0=0. Write x5=0xDEAD_BEEF, assert rst_n=0 for one edge → x5 reads 0.
- Zero register: write x0=0x1234, read x0 → 0. Reserve x0 → rsv_ok=1 and rd_busy for x0 stays 0.
- Write priority: same cycle wr0 x7=0x11, wr1 x7=0x22 → bypassed read returns 0x22 that cycle; stored read returns 0x22 next cycle.
- Bypass on/off: write x3=0xA5 and read x3 in the same cycle (x3 previously 0) → rd_data=0xA5 with BYPASS=1, 0 with BYPASS=0; both read 0xA5 next cycle.
- Scoreboard:
  - reserve x9 → next cycle rd_busy=1 and a second reserve of x9 gives rsv_ok=0;
  - write x9=0x55 → rd_busy=0 that cycle (BYPASS=1) and busy clear next cycle;
  - reserve x9 in the same cycle as that write → rsv_ok=1 and busy=1 afterwards.
- a0 path: write x10=0x0000_0001 → a0=1 exactly one cycle after the write edge, with no same-cycle bypass.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the NPC register file.
package rf_pkg;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_COUNT  = 32;
   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned REG_ZERO  = 0;
   localparam int unsigned REG_A0    = 10;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reservations set busy, writes release it.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
   parameter int unsigned ADDR_COUNT = RF_COUNT,
   parameter int unsigned NR_RD      = 2,
   parameter int unsigned NR_WR      = 2,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NR_RD*ADDR_WIDTH-1:0]   rd_addr,
   input  logic [NR_WR-1:0]              wr_en,
   input  logic [NR_WR*ADDR_WIDTH-1:0]   wr_addr,
   input  logic                          rsv_en,
   input  logic [ADDR_WIDTH-1:0]         rsv_addr,
   output logic                          rsv_ok,
   output logic [NR_RD-1:0]              rd_busy
);

   logic [ADDR_COUNT-1:0] busy;
   logic [ADDR_COUNT-1:0] rel;
   logic [ADDR_COUNT-1:0] set;
   logic                  rsv_valid;
   logic                  rsv_zero;
   logic                  busy_sel;
   logic                  rel_sel;

   // Any enabled write to a register releases it, regardless of port priority
   always_comb begin
      rel = '0;
      for (int unsigned j = 0; j < ADDR_COUNT; j++) begin
         for (int unsigned k = 0; k < NR_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(j)))
               rel[j] = 1'b1;
         end
      end
   end

   // Reservation acceptance; a same-cycle release frees the register for re-issue
   always_comb begin
      rsv_valid = (32'(rsv_addr) < ADDR_COUNT);
      rsv_zero  = (ZERO_REG != 0) && (rsv_addr == ADDR_WIDTH'(REG_ZERO));
      busy_sel  = 1'b0;
      rel_sel   = 1'b0;
      set       = '0;
      for (int unsigned j = 0; j < ADDR_COUNT; j++) begin
         if (rsv_addr == ADDR_WIDTH'(j)) begin
            busy_sel = busy[j];
            rel_sel  = rel[j];
         end
      end
      rsv_ok = rsv_en & (rsv_zero | (rsv_valid & (~busy_sel | rel_sel)));
      for (int unsigned j = 0; j < ADDR_COUNT; j++) begin
         if (rsv_ok && !rsv_zero && (rsv_addr == ADDR_WIDTH'(j)))
            set[j] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= (busy & ~rel) | set;
   end

   // Out-of-range addresses match no entry and read as not busy
   always_comb begin
      rd_busy = '0;
      for (int unsigned i = 0; i < NR_RD; i++) begin
         for (int unsigned j = 0; j < ADDR_COUNT; j++) begin
            if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(j))
               rd_busy[i] = busy[j] & ~((BYPASS != 0) & rel[j]);
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with prioritised writes, optional bypass and busy scoreboard.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
   parameter int unsigned ADDR_COUNT = RF_COUNT,
   parameter int unsigned DATA_WIDTH = RF_DATA_W,
   parameter int unsigned NR_RD      = 2,
   parameter int unsigned NR_WR      = 2,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NR_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NR_RD*DATA_WIDTH-1:0]   rd_data,
   output logic [NR_RD-1:0]              rd_busy,
   input  logic [NR_WR-1:0]              wr_en,
   input  logic [NR_WR*ADDR_WIDTH-1:0]   wr_addr,
   input  logic [NR_WR*DATA_WIDTH-1:0]   wr_data,
   input  logic                          rsv_en,
   input  logic [ADDR_WIDTH-1:0]         rsv_addr,
   output logic                          rsv_ok,
   output logic [DATA_WIDTH-1:0]         a0
);

   logic [DATA_WIDTH-1:0] rf     [ADDR_COUNT];
   logic [DATA_WIDTH-1:0] rf_nxt [ADDR_COUNT];

   // Later ports overwrite earlier ones, so the highest index wins
   always_comb begin
      rf_nxt = rf;
      for (int unsigned j = 0; j < ADDR_COUNT; j++) begin
         if (!((ZERO_REG != 0) && (j == REG_ZERO))) begin
            for (int unsigned k = 0; k < NR_WR; k++) begin
               if (wr_en[k] && (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(j)))
                  rf_nxt[j] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < ADDR_COUNT; j++)
            rf[j] <= '0;
      end else begin
         rf <= rf_nxt;
      end
   end

   // Combinational read with optional same-cycle forwarding
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NR_RD; i++) begin
         logic [ADDR_WIDTH-1:0] a;
         logic [DATA_WIDTH-1:0] d;
         logic                  valid;
         a     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         d     = '0;
         valid = (32'(a) < ADDR_COUNT) &&
                 !((ZERO_REG != 0) && (a == ADDR_WIDTH'(REG_ZERO)));
         if (valid) begin
            for (int unsigned j = 0; j < ADDR_COUNT; j++) begin
               if (a == ADDR_WIDTH'(j))
                  d = rf[j];
            end
            if (BYPASS != 0) begin
               for (int unsigned k = 0; k < NR_WR; k++) begin
                  if (wr_en[k] && (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == a))
                     d = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         rd_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
      end
   end

   assign a0 = rf[REG_A0];

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR_COUNT (ADDR_COUNT),
      .NR_RD      (NR_RD),
      .NR_WR      (NR_WR),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rsv_ok   (rsv_ok),
      .rd_busy  (rd_busy)
   );

endmodule
